// File: rtl/lm32_normalizer.sv
// Iterative leading/trailing-zero normalizer for the LM32 X stage.
// Binary search over shifts of 16, 8, 4, 2, 1: fixed 5-cycle search, then a one-cycle done.
module lm32_normalizer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_x,
    input  logic        kill_x,
    input  logic        normalize_x,
    input  logic        direction_x,
    input  logic [31:0] operand_0_x,
    output logic [31:0] normalize_result_x,
    output logic [5:0]  normalize_count_x,
    output logic        normalize_zero_x,
    output logic        normalize_stall_request_x,
    output logic        normalize_done_x
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]  state;
    logic [2:0]  step;
    logic        direction;
    logic [31:0] result;
    logic [5:0]  count;
    logic        zero;

    logic [4:0]  amt;
    logic [31:0] hi_mask;
    logic [31:0] lo_mask;
    logic [31:0] shifted;
    logic        hit;
    logic        start;

    // step 0..4 selects shift amounts 16, 8, 4, 2, 1
    always_comb begin
        amt     = 5'd16 >> step;
        hi_mask = ~(32'hFFFF_FFFF >> amt);
        lo_mask = ~(32'hFFFF_FFFF << amt);
        if (direction) begin
            hit     = (result & lo_mask) == 32'd0;
            shifted = result >> amt;
        end else begin
            hit     = (result & hi_mask) == 32'd0;
            shifted = result << amt;
        end
    end

    assign start = normalize_x && !stall_x && !kill_x && (state == IDLE || state == DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            step      <= 3'd0;
            direction <= 1'b0;
            result    <= 32'd0;
            count     <= 6'd0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= SEARCH;
                        step      <= 3'd0;
                        direction <= direction_x;
                        result    <= operand_0_x;
                        count     <= 6'd0;
                        zero      <= (operand_0_x == 32'd0);
                    end else begin
                        state <= IDLE;
                    end
                end
                SEARCH: begin
                    // kill leaves the partial result/count visible
                    if (kill_x) begin
                        state <= IDLE;
                    end else begin
                        if (hit) begin
                            result <= shifted;
                            count  <= count + {1'b0, amt};
                        end
                        if (step == 3'd4) begin
                            state <= DONE;
                            step  <= 3'd0;
                            // the search alone tops out at 31 for a zero word
                            if (zero)
                                count <= 6'd32;
                        end else begin
                            step <= step + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign normalize_result_x        = result;
    assign normalize_count_x         = count;
    assign normalize_zero_x          = zero;
    assign normalize_stall_request_x = (state == SEARCH);
    assign normalize_done_x          = (state == DONE);

endmodule

// File: tb/tb_lm32_normalizer.sv
// Directed-vector bench for lm32_normalizer with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_lm32_normalizer;

    logic        clk_i;
    logic        rst_i;
    logic        stall_x;
    logic        kill_x;
    logic        normalize_x;
    logic        direction_x;
    logic [31:0] operand_0_x;
    logic [31:0] normalize_result_x;
    logic [5:0]  normalize_count_x;
    logic        normalize_zero_x;
    logic        normalize_stall_request_x;
    logic        normalize_done_x;

    int n_checks = 0;
    int n_fail   = 0;

    lm32_normalizer dut (
        .clk_i                     (clk_i),
        .rst_i                     (rst_i),
        .stall_x                   (stall_x),
        .kill_x                    (kill_x),
        .normalize_x               (normalize_x),
        .direction_x               (direction_x),
        .operand_0_x               (operand_0_x),
        .normalize_result_x        (normalize_result_x),
        .normalize_count_x         (normalize_count_x),
        .normalize_zero_x          (normalize_zero_x),
        .normalize_stall_request_x (normalize_stall_request_x),
        .normalize_done_x          (normalize_done_x)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present a start request and let it be sampled by the next rising edge.
    task automatic start_op(input logic dir, input logic [31:0] op);
        normalize_x = 1'b1;
        direction_x = dir;
        operand_0_x = op;
        @(posedge clk_i);
        #1 normalize_x = 1'b0;
    endtask

    // Called in cycle N+1: expect 5 stall cycles, then done with the result.
    task automatic finish_op(input string tag, input logic [31:0] res, input logic [5:0] cnt,
                             input logic zro);
        for (int i = 0; i < 5; i++) begin
            check({tag, "_stall"}, normalize_stall_request_x, 1'b1);
            check({tag, "_early_done"}, normalize_done_x, 1'b0);
            @(posedge clk_i);
            #1;
        end
        check({tag, "_done"}, normalize_done_x, 1'b1);
        check({tag, "_stall_off"}, normalize_stall_request_x, 1'b0);
        check({tag, "_result"}, normalize_result_x, res);
        check({tag, "_count"}, normalize_count_x, cnt);
        check({tag, "_zero"}, normalize_zero_x, zro);
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk_i);
        #1;
        check({tag, "_idle_done"}, normalize_done_x, 1'b0);
        check({tag, "_idle_stall"}, normalize_stall_request_x, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i       = 1'b0;
        stall_x     = 1'b0;
        kill_x      = 1'b0;
        normalize_x = 1'b0;
        direction_x = 1'b0;
        operand_0_x = 32'd0;

        #2 rst_i = 1'b1;
        #1;
        check("rst_result", normalize_result_x, 32'd0);
        check("rst_count", normalize_count_x, 6'd0);
        check("rst_zero", normalize_zero_x, 1'b0);
        check("rst_stall", normalize_stall_request_x, 1'b0);
        check("rst_done", normalize_done_x, 1'b0);

        // first start sampled by the first edge after release
        @(negedge clk_i);
        rst_i = 1'b0;
        start_op(1'b0, 32'h0000_0001);
        finish_op("l_one", 32'h8000_0000, 6'd31, 1'b0);
        idle_cycle("l_one");

        start_op(1'b0, 32'h8000_0000);
        finish_op("l_msb", 32'h8000_0000, 6'd0, 1'b0);
        idle_cycle("l_msb");

        start_op(1'b1, 32'h00F0_0000);
        finish_op("r_f0", 32'h0000_000F, 6'd20, 1'b0);
        idle_cycle("r_f0");

        start_op(1'b1, 32'h8000_0000);
        finish_op("r_msb", 32'h0000_0001, 6'd31, 1'b0);
        idle_cycle("r_msb");

        start_op(1'b0, 32'h0000_0000);
        finish_op("l_zero", 32'h0000_0000, 6'd32, 1'b1);
        idle_cycle("l_zero");

        start_op(1'b1, 32'h0000_0000);
        finish_op("r_zero", 32'h0000_0000, 6'd32, 1'b1);
        idle_cycle("r_zero");

        // back-to-back: second start issued in the done cycle
        start_op(1'b0, 32'h0000_0003);
        finish_op("b2b_a", 32'hC000_0000, 6'd30, 1'b0);
        start_op(1'b0, 32'h0001_0000);
        finish_op("b2b_b", 32'h8000_0000, 6'd15, 1'b0);

        // stall_x blocks the start; outputs hold
        stall_x = 1'b1;
        start_op(1'b0, 32'h0000_0010);
        stall_x = 1'b0;
        check("stallx_busy", normalize_stall_request_x, 1'b0);
        check("stallx_hold_res", normalize_result_x, 32'h8000_0000);
        check("stallx_hold_cnt", normalize_count_x, 6'd15);

        // kill with normalize in idle: no capture
        kill_x = 1'b1;
        start_op(1'b0, 32'h0000_0005);
        kill_x = 1'b0;
        check("killidle_busy", normalize_stall_request_x, 1'b0);
        check("killidle_res", normalize_result_x, 32'h8000_0000);

        // kill in the 3rd search cycle: partial values after steps 16 and 8
        start_op(1'b0, 32'h0000_0001);
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        check("kill_busy_before", normalize_stall_request_x, 1'b1);
        kill_x = 1'b1;
        @(posedge clk_i);
        #1 kill_x = 1'b0;
        check("kill_stall_off", normalize_stall_request_x, 1'b0);
        check("kill_partial_res", normalize_result_x, 32'h0100_0000);
        check("kill_partial_cnt", normalize_count_x, 6'd24);
        for (int i = 0; i < 6; i++) begin
            check("kill_no_done", normalize_done_x, 1'b0);
            @(posedge clk_i);
            #1;
        end
        start_op(1'b0, 32'h0000_0100);
        finish_op("after_kill", 32'h8000_0000, 6'd23, 1'b0);
        idle_cycle("after_kill");

        // asynchronous reset mid-search
        start_op(1'b1, 32'h0000_1000);
        @(posedge clk_i);
        #1;
        #3 rst_i = 1'b1;
        #1;
        check("arst_result", normalize_result_x, 32'd0);
        check("arst_count", normalize_count_x, 6'd0);
        check("arst_zero", normalize_zero_x, 1'b0);
        check("arst_stall", normalize_stall_request_x, 1'b0);
        check("arst_done", normalize_done_x, 1'b0);
        #2 rst_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i);
            #1;
            check("arst_no_done", normalize_done_x, 1'b0);
            check("arst_no_stall", normalize_stall_request_x, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
